instr_mem_adapter: RTL and testbench

Line-fill adapter between the instruction cache memory port and a 32-bit OBI-style instruction memory bus. It accepts one cache-line read request from the `instr_cache` memory side, splits it into consecutive word beats on the bus, and assembles the returned words into a full line. It then returns the line with the original tag on the cache's memory-response interface. It is read-only, matching the instruction cache's `WRITE_ENABLE = 0`.

---
 rtl/gpgpu_mem_pkg.sv | 21 ++
 rtl/instr_mem_adapter_if.sv | 36 +++
 rtl/instr_mem_adapter_line_assembler.sv | 55 +++++
 rtl/instr_mem_adapter.sv | 169 ++++++++++++++++
 tb/tb_instr_mem_adapter.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpgpu_mem_pkg.sv
// Shared memory-side definitions for the GPGPU instruction path: cache line
// geometry defaults, the line-fill adapter state encoding and beat helper.
package gpgpu_mem_pkg;

    localparam int unsigned ICACHE_LINE_SIZE     = 16;
    localparam int unsigned ICACHE_MEM_TAG_WIDTH = 8;
    localparam int unsigned OBI_ADDR_WIDTH       = 32;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StResp
    } instr_mem_adapter_state_e;

    // Number of bus beats needed to move one cache line.
    function automatic int unsigned calc_beats(input int unsigned line_size,
                                               input int unsigned bus_width);
        return (line_size * 8) / bus_width;
    endfunction

endpackage

// File: rtl/instr_mem_adapter_if.sv
// Cache memory-side request/response interfaces used by the instruction
// line-fill adapter. The cache drives requests (master) and receives
// responses (slave).
interface VX_mem_req_if
    import gpgpu_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ICACHE_LINE_SIZE * 8,
    parameter int unsigned ADDR_WIDTH = 28,
    parameter int unsigned TAG_WIDTH  = ICACHE_MEM_TAG_WIDTH
);
    logic                    valid;
    logic                    rw;
    logic [DATA_WIDTH/8-1:0] byteen;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   data;
    logic [TAG_WIDTH-1:0]    tag;
    logic                    ready;

    modport master (output valid, rw, byteen, addr, data, tag, input ready);
    modport slave  (input valid, rw, byteen, addr, data, tag, output ready);
endinterface

interface VX_mem_rsp_if
    import gpgpu_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ICACHE_LINE_SIZE * 8,
    parameter int unsigned TAG_WIDTH  = ICACHE_MEM_TAG_WIDTH
);
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0]  tag;
    logic                  ready;

    modport master (output valid, data, tag, input ready);
    modport slave  (input valid, data, tag, output ready);
endinterface

// File: rtl/instr_mem_adapter_line_assembler.sv
// Line assembler: collects in-order read beats into a cache line buffer.
// Beat 0 lands in the lowest bus-width slice.
module line_assembler #(
    parameter int unsigned BEATS     = 4,
    parameter int unsigned BUS_WIDTH = 32,
    parameter int unsigned CNT_W     = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear,
    input  logic                       en,
    input  logic                       rvalid,
    input  logic [BUS_WIDTH-1:0]       rdata,
    output logic [BEATS*BUS_WIDTH-1:0] line,
    output logic                       done
);

    logic [BEATS*BUS_WIDTH-1:0] line_q, line_d;
    logic [CNT_W-1:0]           recv_cnt_q, recv_cnt_d;
    logic                       wr;

    // Saturating guard keeps recv_cnt from ever passing BEATS.
    assign wr   = en && rvalid && (recv_cnt_q < CNT_W'(BEATS));
    // Pulses in the cycle the final beat is written.
    assign done = wr && (recv_cnt_q == CNT_W'(BEATS - 1));
    assign line = line_q;

    // Next-state: clear the beat counter on a new fill, else store one beat.
    always_comb begin
        line_d     = line_q;
        recv_cnt_d = recv_cnt_q;
        if (clear) begin
            recv_cnt_d = '0;
        end else if (wr) begin
            for (int unsigned b = 0; b < BEATS; b++) begin
                if (recv_cnt_q == CNT_W'(b)) begin
                    line_d[b*BUS_WIDTH +: BUS_WIDTH] = rdata;
                end
            end
            recv_cnt_d = recv_cnt_q + CNT_W'(1);
        end
    end

    // Line buffer and beat counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            line_q     <= '0;
            recv_cnt_q <= '0;
        end else begin
            line_q     <= line_d;
            recv_cnt_q <= recv_cnt_d;
        end
    end

endmodule

// File: rtl/instr_mem_adapter.sv
// Instruction cache line-fill adapter: turns one line read into BEATS
// consecutive OBI word reads and returns the assembled line with its tag.
// Read-only; an accepted write only sets the sticky err_o flag.
// Optional: define INSTR_MEM_ADAPTER_PERF_EN to add fill/stall counters.
module instr_mem_adapter
    import gpgpu_mem_pkg::*;
#(
    parameter int unsigned LINE_SIZE       = ICACHE_LINE_SIZE,
    parameter int unsigned LINE_ADDR_WIDTH = 28,
    parameter int unsigned TAG_WIDTH       = ICACHE_MEM_TAG_WIDTH,
    parameter int unsigned BUS_WIDTH       = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    VX_mem_req_if.slave               mem_req,
    VX_mem_rsp_if.master              mem_rsp,
    output logic                      obi_req_o,
    input  logic                      obi_gnt_i,
    output logic [OBI_ADDR_WIDTH-1:0] obi_addr_o,
    output logic                      obi_we_o,
    output logic [BUS_WIDTH/8-1:0]    obi_be_o,
    output logic [BUS_WIDTH-1:0]      obi_wdata_o,
    input  logic                      obi_rvalid_i,
    input  logic [BUS_WIDTH-1:0]      obi_rdata_i,
    output logic                      err_o
`ifdef INSTR_MEM_ADAPTER_PERF_EN
    ,
    output logic [31:0]               perf_fills_o,
    output logic [31:0]               perf_stall_o
`endif
);

    localparam int unsigned BEATS     = calc_beats(LINE_SIZE, BUS_WIDTH);
    localparam int unsigned CNT_W     = $clog2(BEATS) + 1;
    localparam int unsigned OFF_W     = $clog2(LINE_SIZE);
    localparam int unsigned BUS_BYTES = BUS_WIDTH / 8;

    instr_mem_adapter_state_e   state_q, state_d;
    logic [CNT_W-1:0]           issue_cnt_q, issue_cnt_d;
    logic [LINE_ADDR_WIDTH-1:0] line_addr_q, line_addr_d;
    logic [TAG_WIDTH-1:0]       tag_q, tag_d;
    logic                       err_q, err_d;

    logic                       fetch;
    logic                       req_hs;
    logic                       rsp_hs;
    logic                       issue_hs;
    logic                       asm_clear;
    logic                       asm_done;
    logic [OBI_ADDR_WIDTH-1:0]  beat_addr;
    logic                       unused_req;

    // Write payload is never consumed by a read-only adapter.
    assign unused_req = ^{mem_req.byteen, mem_req.data};

    assign fetch         = (state_q == StFetch);
    assign mem_req.ready = (state_q == StIdle);
    assign req_hs        = mem_req.valid && mem_req.ready;
    assign obi_req_o     = fetch && (issue_cnt_q < CNT_W'(BEATS));
    assign issue_hs      = obi_req_o && obi_gnt_i;
    assign mem_rsp.valid = (state_q == StResp);
    assign rsp_hs        = mem_rsp.valid && mem_rsp.ready;
    assign mem_rsp.tag   = tag_q;
    assign err_o         = err_q;

    // Line base plus beat offset, wrapped to the bus address width.
    assign beat_addr  = OBI_ADDR_WIDTH'((64'(line_addr_q) << OFF_W)
                                        + 64'(issue_cnt_q) * 64'(BUS_BYTES));
    assign obi_addr_o = fetch ? beat_addr : '0;

    assign obi_we_o    = 1'b0;
    assign obi_be_o    = '1;
    assign obi_wdata_o = '0;

    line_assembler #(
        .BEATS     (BEATS),
        .BUS_WIDTH (BUS_WIDTH),
        .CNT_W     (CNT_W)
    ) u_line_assembler (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clear  (asm_clear),
        .en     (fetch),
        .rvalid (obi_rvalid_i),
        .rdata  (obi_rdata_i),
        .line   (mem_rsp.data),
        .done   (asm_done)
    );

    // Next-state: accept requests in idle, issue beats in fetch, hand off in resp.
    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        line_addr_d = line_addr_q;
        tag_d       = tag_q;
        err_d       = err_q;
        asm_clear   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_hs) begin
                    if (mem_req.rw) begin
                        err_d = 1'b1;
                    end else begin
                        line_addr_d = mem_req.addr;
                        tag_d       = mem_req.tag;
                        issue_cnt_d = '0;
                        asm_clear   = 1'b1;
                        state_d     = StFetch;
                    end
                end
            end
            StFetch: begin
                if (issue_hs) begin
                    issue_cnt_d = issue_cnt_q + CNT_W'(1);
                end
                if (asm_done) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_hs) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state and request context registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            issue_cnt_q <= '0;
            line_addr_q <= '0;
            tag_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            line_addr_q <= line_addr_d;
            tag_q       <= tag_d;
            err_q       <= err_d;
        end
    end

`ifdef INSTR_MEM_ADAPTER_PERF_EN
    logic [31:0] perf_fills_q;
    logic [31:0] perf_stall_q;

    // Event counters: completed fills and cycles stalled waiting for grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_fills_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (rsp_hs) begin
                perf_fills_q <= perf_fills_q + 32'd1;
            end
            if (obi_req_o && !obi_gnt_i) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fills_o = perf_fills_q;
    assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_instr_mem_adapter.sv
// Self-checking bench for instr_mem_adapter: directed fills plus random
// back-to-back fills against a queue-based memory and response scoreboard.
module tb_instr_mem_adapter;
    import gpgpu_mem_pkg::*;

    localparam int unsigned LINE_SIZE = 16;
    localparam int unsigned LAW       = 28;
    localparam int unsigned TW        = ICACHE_MEM_TAG_WIDTH;
    localparam int unsigned BW        = 32;
    localparam int unsigned NBEATS    = LINE_SIZE * 8 / BW;
    localparam int unsigned LBITS     = LINE_SIZE * 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    VX_mem_req_if #(.DATA_WIDTH(LBITS), .ADDR_WIDTH(LAW), .TAG_WIDTH(TW)) mem_req ();
    VX_mem_rsp_if #(.DATA_WIDTH(LBITS), .TAG_WIDTH(TW)) mem_rsp ();

    logic          obi_req, obi_gnt, obi_we, obi_rvalid, err;
    logic [31:0]   obi_addr, obi_rdata;
    logic [BW-1:0] obi_wdata;
    logic [3:0]    obi_be;
`ifdef INSTR_MEM_ADAPTER_PERF_EN
    logic [31:0]   perf_fills, perf_stall;
`endif

    instr_mem_adapter #(
        .LINE_SIZE       (LINE_SIZE),
        .LINE_ADDR_WIDTH (LAW),
        .TAG_WIDTH       (TW),
        .BUS_WIDTH       (BW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .mem_req      (mem_req),
        .mem_rsp      (mem_rsp),
        .obi_req_o    (obi_req),
        .obi_gnt_i    (obi_gnt),
        .obi_addr_o   (obi_addr),
        .obi_we_o     (obi_we),
        .obi_be_o     (obi_be),
        .obi_wdata_o  (obi_wdata),
        .obi_rvalid_i (obi_rvalid),
        .obi_rdata_i  (obi_rdata),
        .err_o        (err)
`ifdef INSTR_MEM_ADAPTER_PERF_EN
        ,
        .perf_fills_o (perf_fills),
        .perf_stall_o (perf_stall)
`endif
    );

    typedef struct {
        logic [LBITS-1:0] data;
        logic [TW-1:0]    tag;
    } rsp_t;
    typedef struct {
        logic [31:0] data;
        int          due;
    } beat_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    rsp_t        exp_rsp_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_word_q[$];
    beat_t       pend_q[$];
    int          gnt_cyc_q[$];
    int          rvalid_count = 0;

    // Knobs for the memory model and response sink.
    bit          gnt_rand = 0;
    int          lat_max = 0;
    logic [31:0] hold_addr = '0;
    int          hold_left = 0;
    bit          rsp_rand = 0;
    int          rsp_block = 0;

    int rsp_first_cyc = -1;
    int rsp_hs_cyc = -1;
    int rsp_seen = 0;

    task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory model: in-order returns with optional grant stalls and latency.
    initial begin
        bit          prev_stall;
        logic [31:0] prev_addr;
        prev_stall = 0;
        prev_addr  = '0;
        obi_gnt    = 1'b0;
        obi_rvalid = 1'b0;
        obi_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                pend_q.delete();
                obi_gnt    = 1'b0;
                obi_rvalid = 1'b0;
                prev_stall = 0;
                continue;
            end
            if (prev_stall) begin
                check_eq("obi_req_held", 128'(obi_req), 128'(1));
                check_eq("obi_addr_held", 128'(obi_addr), 128'(prev_addr));
            end
            check_eq("obi_const", {obi_we, obi_be, obi_wdata}, {1'b0, 4'hf, 32'h0});
            if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
                obi_rvalid = 1'b1;
                obi_rdata  = pend_q[0].data;
                void'(pend_q.pop_front());
                rvalid_count++;
            end else begin
                obi_rvalid = 1'b0;
                obi_rdata  = $urandom;
            end
            obi_gnt = 1'b0;
            if (obi_req) begin
                check_eq("obi_req_expected", 128'(exp_addr_q.size() != 0), 128'(1));
                if (hold_left > 0 && obi_addr == hold_addr) begin
                    hold_left--;
                end else if (!(gnt_rand && $urandom_range(3) == 0)) begin
                    obi_gnt = 1'b1;
                end
                if (obi_gnt && exp_addr_q.size() != 0 && exp_word_q.size() != 0) begin
                    check_eq("obi_addr", 128'(obi_addr), 128'(exp_addr_q.pop_front()));
                    pend_q.push_back('{exp_word_q.pop_front(), cyc + 1 + $urandom_range(lat_max)});
                    gnt_cyc_q.push_back(cyc);
                end
            end else begin
                obi_gnt = gnt_rand && ($urandom_range(1) == 1);
            end
            prev_stall = obi_req && !obi_gnt;
            prev_addr  = obi_addr;
        end
    end

    // Response sink: ready pattern driven after each active edge.
    initial begin
        mem_rsp.ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_rsp.valid && rsp_block > 0) begin
                mem_rsp.ready = 1'b0;
                rsp_block--;
            end else begin
                mem_rsp.ready = rsp_rand ? ($urandom_range(2) != 0) : 1'b1;
            end
        end
    end

    // Response monitor: pop scoreboard on each new response, check hold while stalled.
    initial begin
        bit               stalled;
        logic [LBITS-1:0] held_data;
        logic [TW-1:0]    held_tag;
        rsp_t             e;
        stalled = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 0;
            end else if (mem_rsp.valid) begin
                check_eq("req_ready_during_rsp", 128'(mem_req.ready), 128'(0));
                if (stalled) begin
                    check_eq("rsp_data_held", 128'(mem_rsp.data), 128'(held_data));
                    check_eq("rsp_tag_held", 128'(mem_rsp.tag), 128'(held_tag));
                end else begin
                    rsp_first_cyc = cyc;
                    check_eq("rsp_expected", 128'(exp_rsp_q.size() != 0), 128'(1));
                    if (exp_rsp_q.size() != 0) begin
                        e = exp_rsp_q.pop_front();
                        check_eq("rsp_data", 128'(mem_rsp.data), 128'(e.data));
                        check_eq("rsp_tag", 128'(mem_rsp.tag), 128'(e.tag));
                    end
                end
                held_data = mem_rsp.data;
                held_tag  = mem_rsp.tag;
                stalled   = !mem_rsp.ready;
                if (mem_rsp.ready) begin
                    rsp_hs_cyc = cyc;
                    rsp_seen++;
                end
            end else begin
                stalled = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got %0d cycles, expected fewer", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic issue_req(input logic [LAW-1:0] la, input logic [TW-1:0] tag,
                             input logic rw, output int acc);
        @(posedge clk);
        #1;
        mem_req.valid  = 1'b1;
        mem_req.rw     = rw;
        mem_req.addr   = la;
        mem_req.tag    = tag;
        mem_req.byteen = '1;
        mem_req.data   = {$urandom, $urandom, $urandom, $urandom};
        for (int n = 0; n < 2000 && !mem_req.ready; n++) begin
            @(posedge clk);
            #1;
        end
        if (!mem_req.ready) check_eq("req_accept_timeout", 128'(mem_req.ready), 128'(1));
        acc = cyc;
        @(posedge clk);
        #1;
        mem_req.valid = 1'b0;
        mem_req.rw    = 1'b0;
    endtask

    // Reference: line = beats in ascending address order, beat i at {la,0}+4i.
    task automatic send_fill(input logic [LAW-1:0] la, input logic [TW-1:0] tag,
                             input logic [LBITS-1:0] line, output int acc);
        for (int i = 0; i < int'(NBEATS); i++) begin
            exp_addr_q.push_back(32'({4'b0, la} * 16 + 4 * i));
            exp_word_q.push_back(line[i*32 +: 32]);
        end
        exp_rsp_q.push_back('{line, tag});
        issue_req(la, tag, 1'b0, acc);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_rsp_q.size() != 0 || mem_rsp.valid) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= budget) check_eq("fill_timeout", 128'(exp_rsp_q.size()), 128'(0));
    endtask

    task automatic check_reset_values();
        check_eq("rst_req_ready", 128'(mem_req.ready), 128'(1));
        check_eq("rst_rsp_valid", 128'(mem_rsp.valid), 128'(0));
        check_eq("rst_obi_req", 128'(obi_req), 128'(0));
        check_eq("rst_obi_addr", 128'(obi_addr), 128'(0));
        check_eq("rst_err", 128'(err), 128'(0));
        check_eq("rst_rsp_data", 128'(mem_rsp.data), 128'(0));
        check_eq("rst_rsp_tag", 128'(mem_rsp.tag), 128'(0));
`ifdef INSTR_MEM_ADAPTER_PERF_EN
        check_eq("rst_perf", {perf_fills, perf_stall}, 64'h0);
`endif
    endtask

    initial begin
        int               t;
        int               seen0;
        int               rv0;
        logic [LBITS-1:0] ln;
`ifdef INSTR_MEM_ADAPTER_PERF_EN
        logic [31:0]      pf0, ps0;
`endif
        mem_req.valid  = 1'b0;
        mem_req.rw     = 1'b0;
        mem_req.addr   = '0;
        mem_req.tag    = '0;
        mem_req.byteen = '0;
        mem_req.data   = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Zero-wait single fill: beats at T+1..T+4, response at T+6.
        gnt_cyc_q.delete();
        send_fill(28'h40, 8'h5, {32'h44, 32'h33, 32'h22, 32'h11}, t);
        wait_idle(200);
        check_eq("gnt_count", 128'(gnt_cyc_q.size()), 128'(4));
        for (int i = 0; i < 4 && i < gnt_cyc_q.size(); i++) begin
            check_eq("gnt_cycle", 128'(gnt_cyc_q[i] - t), 128'(i + 1));
        end
        check_eq("zero_wait_rsp_cycle", 128'(rsp_first_cyc - t), 128'(6));

        // Grant withheld three cycles on beat 2.
`ifdef INSTR_MEM_ADAPTER_PERF_EN
        ps0 = perf_stall;
`endif
        hold_addr = 32'h408;
        hold_left = 3;
        send_fill(28'h40, 8'h6, {$urandom, $urandom, $urandom, $urandom}, t);
        wait_idle(200);
        check_eq("stall_rsp_cycle", 128'(rsp_first_cyc - t), 128'(9));
`ifdef INSTR_MEM_ADAPTER_PERF_EN
        check_eq("perf_stall", 128'(perf_stall - ps0), 128'(3));
`endif

        // Response back-pressure for five cycles.
        rsp_block = 5;
        send_fill(28'(24'hab_cdef), 8'h7a, {$urandom, $urandom, $urandom, $urandom}, t);
        wait_idle(200);
        check_eq("rsp_hold_cycles", 128'(rsp_hs_cyc - rsp_first_cyc), 128'(5));
        check_eq("req_ready_after_hs", 128'(mem_req.ready), 128'(1));
        check_eq("req_ready_after_hs_cycle", 128'(cyc - rsp_hs_cyc), 128'(1));

        // Write request: flagged, no bus traffic, no response.
        seen0 = rsp_seen;
        issue_req(28'h99, 8'h3, 1'b1, t);
        check_eq("err_next_cycle", 128'(err), 128'(1));
        repeat (10) @(posedge clk);
        #1;
        check_eq("err_sticky", 128'(err), 128'(1));
        check_eq("write_no_rsp", 128'(rsp_seen - seen0), 128'(0));
        check_eq("write_req_ready", 128'(mem_req.ready), 128'(1));

        // Reset after two of four beats, then a fresh fill.
        rv0 = rvalid_count;
        send_fill(28'h123, 8'h21, {$urandom, $urandom, $urandom, $urandom}, t);
        for (int n = 0; n < 200 && rvalid_count < rv0 + 2; n++) begin
            @(posedge clk);
            #1;
        end
        check_eq("mid_fill_beats", 128'(rvalid_count - rv0), 128'(2));
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values();
        exp_rsp_q.delete();
        exp_addr_q.delete();
        exp_word_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        ln = {$urandom, $urandom, $urandom, $urandom};
        send_fill(28'h10, 8'h44, ln, t);
        wait_idle(200);
        check_eq("post_reset_rsp_cycle", 128'(rsp_first_cyc - t), 128'(6));

        // 100 random back-to-back fills with random latency and back-pressure.
        gnt_rand = 1;
        lat_max  = 3;
        rsp_rand = 1;
        seen0    = rsp_seen;
`ifdef INSTR_MEM_ADAPTER_PERF_EN
        pf0 = perf_fills;
`endif
        for (int k = 0; k < 100; k++) begin
            send_fill(28'($urandom), 8'($urandom),
                      {$urandom, $urandom, $urandom, $urandom}, t);
        end
        wait_idle(5000);
        check_eq("random_fill_count", 128'(rsp_seen - seen0), 128'(100));
`ifdef INSTR_MEM_ADAPTER_PERF_EN
        check_eq("perf_fills", 128'(perf_fills - pf0), 128'(100));
`endif
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
